// File: rtl/hidden1_sched.sv
// hidden1_sched: time-multiplexed 7->128 hidden layer sequencer with LANES shared MAC lanes
module hidden1_sched #(
  parameter int N_IN = 7,
  parameter int N_OUT = 128,
  parameter int LANES = 4,
  parameter int IN_W = 4,
  parameter int W_W = 9,
  parameter int ACC_W = 30,
  parameter int SHIFT = 9,
  localparam int N_GRP = N_OUT / LANES,
  localparam int AW = $clog2(N_GRP * N_IN),
  localparam int GW = $clog2(N_GRP),
  localparam int JW = $clog2(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [N_IN*IN_W-1:0]   in_vec,
  output logic                   busy,
  output logic                   done,
  output logic                   w_rd_en,
  output logic [AW-1:0]          w_addr,
  input  logic [LANES*W_W-1:0]   w_rdata,
  output logic                   b_rd_en,
  output logic [GW-1:0]          b_addr,
  input  logic [LANES*W_W-1:0]   b_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [GW-1:0]          out_addr,
  output logic [LANES*W_W-1:0]   out_data
);
  typedef enum logic [2:0] {IDLE, MAC, BIAS, FIN, WRITE, DONE} state_t;
  localparam logic [JW-1:0] J_LAST = JW'(N_IN - 1);
  localparam logic [GW-1:0] G_LAST = GW'(N_GRP - 1);
  state_t state;
  logic [GW-1:0] g;
  logic [JW-1:0] j, j_d;
  logic rd_d;
  logic [N_IN*IN_W-1:0] in_q;
  logic signed [ACC_W-1:0] acc [LANES];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      g <= '0;
      j <= '0;
      j_d <= '0;
      rd_d <= 1'b0;
      in_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      w_rd_en <= 1'b0;
      w_addr <= '0;
      b_rd_en <= 1'b0;
      b_addr <= '0;
      out_valid <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
      for (int k = 0; k < LANES; k++) acc[k] <= '0;
    end else begin
      // weight data lags its read strobe by one cycle, so index the input with the delayed j
      rd_d <= w_rd_en;
      j_d <= j;
      if (rd_d)
        for (int k = 0; k < LANES; k++)
          acc[k] <= acc[k] + ACC_W'($signed(in_q[j_d*IN_W +: IN_W])) * ACC_W'($signed(w_rdata[k*W_W +: W_W]));
      case (state)
        IDLE: if (start) begin
          in_q <= in_vec;
          g <= '0;
          j <= '0;
          w_addr <= '0;
          w_rd_en <= 1'b1;
          busy <= 1'b1;
          for (int k = 0; k < LANES; k++) acc[k] <= '0;
          state <= MAC;
        end
        MAC: if (j == J_LAST) begin
          w_rd_en <= 1'b0;
          b_rd_en <= 1'b1;
          b_addr <= g;
          state <= BIAS;
        end else begin
          j <= j + 1'b1;
          w_addr <= w_addr + 1'b1;
        end
        BIAS: begin
          b_rd_en <= 1'b0;
          state <= FIN;
        end
        FIN: begin
          for (int k = 0; k < LANES; k++)
            out_data[k*W_W +: W_W] <= W_W'((acc[k] + ACC_W'($signed(b_rdata[k*W_W +: W_W]))) >>> SHIFT);
          out_addr <= g;
          out_valid <= 1'b1;
          state <= WRITE;
        end
        WRITE: if (out_ready) begin
          out_valid <= 1'b0;
          for (int k = 0; k < LANES; k++) acc[k] <= '0;
          if (g == G_LAST) begin
            done <= 1'b1;
            state <= DONE;
          end else begin
            g <= g + 1'b1;
            j <= '0;
            w_addr <= AW'((32'(g) + 1) * N_IN);
            w_rd_en <= 1'b1;
            state <= MAC;
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
